// File: rtl/fb_pkg.sv
// Shared constants, FSM state encoding and burst address helper for the
// SDRAM frame-buffer scheduler.
package fb_pkg;

    localparam int unsigned BURST_LEN_DEF    = 256;
    localparam int unsigned FRAME_BURSTS_DEF = 750;
    localparam logic [31:0] BUF_STRIDE_DEF   = 32'h0004_0000;

    typedef logic [1:0] fb_state_t;
    localparam fb_state_t ST_IDLE  = 2'd0;
    localparam fb_state_t ST_ARB   = 2'd1;
    localparam fb_state_t ST_ISSUE = 2'd2;
    localparam fb_state_t ST_BUSY  = 2'd3;

    // Burst start address; the caller truncates to its own address width.
    function automatic logic [31:0] addr_calc(
        input logic        buf_sel,
        input logic [15:0] idx,
        input logic [31:0] stride,
        input logic [31:0] burst_len
    );
        addr_calc = (buf_sel ? stride : 32'd0) + 32'(idx) * burst_len;
    endfunction

endpackage

// File: rtl/fb_arb_pick.sv
// Combinational burst arbitration: urgent read first, otherwise write/read
// alternate via the last-served flag when both qualify.
module fb_arb_pick #(
    parameter int unsigned LVL_W      = 10,
    parameter int unsigned BURST_LEN  = 256,
    parameter int unsigned RD_LOW_WM  = 64,
    parameter int unsigned FIFO_DEPTH = 512
) (
    input  logic [LVL_W-1:0] i_wr_fifo_level,
    input  logic [LVL_W-1:0] i_rd_fifo_level,
    input  logic             i_swap_pending,
    input  logic             i_rd_allowed,
    input  logic             i_last_wr,
    output logic             o_grant_wr,
    output logic             o_grant_valid
);

    logic w_urgent;
    logic w_wr_ok;
    logic w_rd_ok;

    assign w_urgent = i_rd_allowed && (32'(i_rd_fifo_level) < RD_LOW_WM);
    assign w_wr_ok  = !i_swap_pending && (32'(i_wr_fifo_level) >= BURST_LEN);
    // Free-space test rearranged so an over-full level cannot go negative.
    assign w_rd_ok  = i_rd_allowed && (32'(i_rd_fifo_level) + BURST_LEN <= FIFO_DEPTH);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs (no latch).
        o_grant_valid = 1'b0;
        o_grant_wr    = 1'b0;
        if (w_urgent) begin
            o_grant_valid = 1'b1;
        end else if (w_wr_ok && w_rd_ok) begin
            o_grant_valid = 1'b1;
            o_grant_wr    = ~i_last_wr;
        end else if (w_wr_ok) begin
            o_grant_valid = 1'b1;
            o_grant_wr    = 1'b1;
        end else if (w_rd_ok) begin
            o_grant_valid = 1'b1;
        end
    end

endmodule

// File: rtl/sdram_fb_sched.sv
// Frame-buffer scheduler: picks write/read full-page bursts for one SDRAM
// burst engine and double-buffers frames, swapping only at LCD frame start.
module sdram_fb_sched
    import fb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 24,
    parameter int unsigned LVL_W        = 10,
    parameter int unsigned BURST_LEN    = BURST_LEN_DEF,
    parameter int unsigned FRAME_BURSTS = FRAME_BURSTS_DEF,
    parameter logic [31:0] BUF_STRIDE   = BUF_STRIDE_DEF,
    parameter int unsigned RD_LOW_WM    = 64,
    parameter int unsigned FIFO_DEPTH   = 512
) (
    input  logic              i_clk_50m,
    input  logic              i_rst,
    input  logic              i_sdram_init_done,
    input  logic [LVL_W-1:0]  i_wr_fifo_level,
    input  logic [LVL_W-1:0]  i_rd_fifo_level,
    input  logic              i_rd_frame_sync,
    output logic              o_cmd_req,
    output logic              o_cmd_wr,
    output logic [ADDR_W-1:0] o_cmd_addr,
    input  logic              i_cmd_ack,
    input  logic              i_burst_done,
    output logic              o_wr_buf,
    output logic              o_rd_buf,
    output logic              o_frame_swapped
);

    localparam int unsigned      IDX_W    = $clog2(FRAME_BURSTS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BURSTS - 1);
    localparam logic [IDX_W-1:0] SAT_IDX  = IDX_W'(FRAME_BURSTS);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    fb_state_t         r_state;
    logic              r_cmd_req;
    logic              r_cmd_wr;
    logic [ADDR_W-1:0] r_cmd_addr;
    logic              r_wr_buf;
    logic              r_rd_buf;
    logic              r_frame_swapped;
    logic [IDX_W-1:0]  r_wr_idx;
    logic [IDX_W-1:0]  r_rd_idx;
    logic              r_swap_pending;
    logic              r_last_wr;
    logic              r_grant_wr;
    logic              r_stale_rd;

    logic              w_grant_wr;
    logic              w_grant_valid;
    logic [ADDR_W-1:0] w_addr_next;
    logic              w_burst_fin;
    logic              w_frame_wrap;
    logic              w_do_swap;
    logic              w_rd_outstanding;

    fb_arb_pick #(
        .LVL_W      (LVL_W),
        .BURST_LEN  (BURST_LEN),
        .RD_LOW_WM  (RD_LOW_WM),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_arb (
        .i_wr_fifo_level (i_wr_fifo_level),
        .i_rd_fifo_level (i_rd_fifo_level),
        .i_swap_pending  (r_swap_pending),
        .i_rd_allowed    (r_rd_idx != SAT_IDX),
        .i_last_wr       (r_last_wr),
        .o_grant_wr      (w_grant_wr),
        .o_grant_valid   (w_grant_valid)
    );

    assign w_addr_next = ADDR_W'(addr_calc(w_grant_wr ? r_wr_buf : r_rd_buf,
                                           16'(w_grant_wr ? r_wr_idx : r_rd_idx),
                                           BUF_STRIDE, BURST_LEN));

    assign w_burst_fin  = (r_state == ST_BUSY) && i_burst_done;
    assign w_frame_wrap = w_burst_fin && r_grant_wr && (r_wr_idx == LAST_IDX);
    // A write frame finishing in the sync cycle still swaps in that cycle.
    assign w_do_swap    = i_rd_frame_sync && (r_swap_pending || w_frame_wrap);

    // Any read whose burst_done lands after this sync belongs to the old frame.
    assign w_rd_outstanding =
        (!r_grant_wr && ((r_state == ST_ISSUE) || ((r_state == ST_BUSY) && !i_burst_done))) ||
        ((r_state == ST_ARB) && i_sdram_init_done && w_grant_valid && !w_grant_wr);

    // NOTE: sequential state uses non-blocking assignments only, so later
    // assignments in this block deliberately override earlier ones.
    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            r_state         <= ST_IDLE;
            r_cmd_req       <= 1'b0;
            r_cmd_wr        <= 1'b0;
            r_cmd_addr      <= '0;
            r_wr_buf        <= 1'b0;
            r_rd_buf        <= 1'b1;
            r_frame_swapped <= 1'b0;
            r_wr_idx        <= '0;
            r_rd_idx        <= '0;
            r_swap_pending  <= 1'b0;
            r_last_wr       <= 1'b0;
            r_grant_wr      <= 1'b0;
            r_stale_rd      <= 1'b0;
        end else begin
            r_frame_swapped <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_sdram_init_done) r_state <= ST_ARB;
                end
                ST_ARB: begin
                    if (!i_sdram_init_done) begin
                        r_state <= ST_IDLE;
                    end else if (w_grant_valid) begin
                        r_state    <= ST_ISSUE;
                        r_cmd_req  <= 1'b1;
                        r_cmd_wr   <= w_grant_wr;
                        r_cmd_addr <= w_addr_next;
                        r_grant_wr <= w_grant_wr;
                        r_last_wr  <= w_grant_wr;
                    end
                end
                ST_ISSUE: begin
                    if (i_cmd_ack) begin
                        r_cmd_req <= 1'b0;
                        r_state   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (i_burst_done) begin
                        r_state <= i_sdram_init_done ? ST_ARB : ST_IDLE;
                        if (r_grant_wr) begin
                            if (r_wr_idx == LAST_IDX) begin
                                r_wr_idx       <= '0;
                                r_swap_pending <= 1'b1;
                            end else begin
                                r_wr_idx <= r_wr_idx + IDX_ONE;
                            end
                        end else if (r_stale_rd) begin
                            r_stale_rd <= 1'b0;
                        end else if (r_rd_idx != SAT_IDX) begin
                            r_rd_idx <= r_rd_idx + IDX_ONE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (i_rd_frame_sync) begin
                r_rd_idx <= '0;
                if (w_rd_outstanding) r_stale_rd <= 1'b1;
                if (w_do_swap) begin
                    r_rd_buf        <= r_wr_buf;
                    r_wr_buf        <= ~r_wr_buf;
                    r_swap_pending  <= 1'b0;
                    r_frame_swapped <= 1'b1;
                end
            end
        end
    end

    assign o_cmd_req       = r_cmd_req;
    assign o_cmd_wr        = r_cmd_wr;
    assign o_cmd_addr      = r_cmd_addr;
    assign o_wr_buf        = r_wr_buf;
    assign o_rd_buf        = r_rd_buf;
    assign o_frame_swapped = r_frame_swapped;

endmodule
